// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_Z     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_ILL   = 3'b111
  } imm_type_e;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction from instruction bits [31:7].
// Every variant is first built as a 32-bit value and then widened by copying bit 31.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     raw_src,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [31:0] v32;

  // Zero-extended variants keep bit 31 clear, so the final widening is a plain sign copy.
  always_comb begin
    v32 = '0;
    err = 1'b0;
    case (imm_type)
      IMM_I: v32 = {{20{raw_src[31]}}, raw_src[31:20]};
      IMM_S: v32 = {{20{raw_src[31]}}, raw_src[31:25], raw_src[11:7]};
      IMM_B: v32 = {{19{raw_src[31]}}, raw_src[31], raw_src[7], raw_src[30:25],
                    raw_src[11:8], 1'b0};
      IMM_J: v32 = {{11{raw_src[31]}}, raw_src[31], raw_src[19:12], raw_src[20],
                    raw_src[30:21], 1'b0};
      IMM_U: v32 = {raw_src[31:12], 12'b0};
      IMM_Z: v32 = {27'b0, raw_src[19:15]};
      IMM_SHAMT: begin
        if (XLEN == 64) begin
          v32 = {26'b0, raw_src[25:20]};
        end else begin
          v32 = {27'b0, raw_src[24:20]};
          err = raw_src[25];
        end
      end
      IMM_ILL: err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  if (XLEN == 64) begin : g_rv64
    assign imm = {{32{v32[31]}}, v32};
  end else begin : g_rv32
    assign imm = v32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry in-order output buffer.
// Define IMM_GEN_STATS_EN to build the accept and error-result counters.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      raw_src,
  input  logic [2:0]       imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [31:0]      stat_cnt,
  output logic [15:0]      stat_err_cnt
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(BUF_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t          mem_q [BUF_DEPTH];
  entry_t          mem_d [BUF_DEPTH];
  entry_t          head;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [XLEN-1:0] ext_imm;
  logic            ext_err;
  logic            push, pop;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .raw_src (raw_src),
    .imm_type(imm_type_e'(imm_type)),
    .imm     (ext_imm),
    .err     (ext_err)
  );

  assign in_ready  = count_q < Full;
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{imm: ext_imm, tag: in_tag, err: ext_err};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign imm_out = head.imm;
  assign out_tag = head.tag;
  assign out_err = head.err;

`ifdef IMM_GEN_STATS_EN
  logic [31:0] stat_cnt_q, stat_cnt_d;
  logic [15:0] stat_err_cnt_q, stat_err_cnt_d;

  always_comb begin
    stat_cnt_d     = stat_cnt_q;
    stat_err_cnt_d = stat_err_cnt_q;
    if (push) begin
      stat_cnt_d = stat_cnt_q + 32'd1;
    end
    // Error counter saturates rather than wrapping.
    if (pop && head.err && (stat_err_cnt_q != 16'hFFFF)) begin
      stat_err_cnt_d = stat_err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q     <= '0;
      stat_err_cnt_q <= '0;
    end else begin
      stat_cnt_q     <= stat_cnt_d;
      stat_err_cnt_q <= stat_err_cnt_d;
    end
  end

  assign stat_cnt     = stat_cnt_q;
  assign stat_err_cnt = stat_err_cnt_q;
`else
  assign stat_cnt     = '0;
  assign stat_err_cnt = '0;
`endif

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts instruction bits [31:7] plus an immediate-type code over a valid/ready handshake, and produces a sign- or zero-extended XLEN immediate one cycle later. A 2-entry output buffer absorbs backpressure from execute. It adds RV64 width, CSR/shift immediates, an illegal-type flag and a transaction tag.

Parameters:
XLEN, 32, immediate output width; legal values are 32 and 64.
TAG_W, 4, width of the sideband tag carried alongside each request (ROB or PC index).

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  block can accept a request.
raw_src  in  25 ([31:7])  instruction bits, opcode stripped.
imm_type  in  3  immediate variant; encoding in Behaviour.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
imm_out  out  XLEN  generated immediate.
out_tag  out  TAG_W  tag of the result.
out_err  out  1  illegal imm_type or illegal shamt.
stat_cnt  out  32  accepted-request counter (see Optional Feature).
stat_err_cnt  out  16  error-result counter (see Optional Feature).

Behaviour:
- Accept condition: in_valid && in_ready. Deliver condition: out_valid && out_ready.
- Reset values: out_valid=0, imm_out=0, out_tag=0, out_err=0, both counters=0, internal count=0.
- in_ready = (count < 2). It is a combinational function of registered count only and never depends on out_ready.
- Latency: a request accepted in cycle N is visible at the output in cycle N+1 if the buffer was empty. There is no combinational input-to-output path.
- Storage: 2-entry FIFO, in strict order. The head entry drives imm_out, out_tag and out_err. Entry fields are {imm, tag, err}.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. This is legal at count 1; at count 2 a push cannot occur.
- Output stability: while out_valid=1 and out_ready=0, all output fields hold stable.
- Pointer wrap: read and write pointers are 1 bit each and wrap 1->0.
- imm_type encoding (sx = sign-extend to XLEN using raw_src[31]):
  - 000 I: sx(raw_src[31:20]).
  - 001 S: sx({raw_src[31:25], raw_src[11:7]}).
  - 010 B: sx({raw_src[31], raw_src[7], raw_src[30:25], raw_src[11:8], 0}).
  - 011 J: sx({raw_src[31], raw_src[19:12], raw_src[20], raw_src[30:21], 0}).
  - 100 U: sx({raw_src[31:12], 12'b0}). For XLEN=64, bits 63:32 copy bit 31.
  - 101 Z (CSR uimm): zero-extend raw_src[19:15].
  - 110 SHAMT: XLEN=64 gives zero-extended raw_src[25:20]. XLEN=32 gives zero-extended raw_src[24:20], and err=1 if raw_src[25]=1.
  - 111: imm=0, err=1.
- Error results still occupy a slot and are delivered normally; err is informational only.
- Reset mid-operation: all buffered entries are discarded immediately; out_valid drops asynchronously.
- Elaboration check: XLEN not in {32, 64} is a fatal elaboration error.

Optional Feature:
Macro IMM_GEN_STATS_EN.
- Defined:
  - stat_cnt increments on every accept and wraps at 2^32.
  - stat_err_cnt increments on every delivered result with err=1, and saturates at 0xFFFF.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Package imm_gen_pkg:
  - imm_type_e enum: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SHAMT, IMM_ILL.
  - Constant BUF_DEPTH=2.
  - Packed entry struct, parametrised via XLEN/TAG_W localparams in the top.
- Sub-module imm_extract: purely combinational. It takes raw_src and imm_type and returns imm and err, parametrised by XLEN. The top holds the FIFO, handshake and counters.

Test Plan:
- XLEN=32, I-type, raw_src from 0xFFF00093 -> next cycle out_valid=1, imm_out=0xFFFFFFFF, err=0, out_tag echoes in_tag=0x3.
- B-type 0xFE000EE3 -> 0xFFFFFFFC; J-type 0x0080006F -> 0x00000008; U-type 0x123450B7 -> 0x12345000; issued back-to-back with out_ready=1, so one result per cycle in order.
- Z-type 0x340FD073 -> 0x0000001F. SHAMT with raw_src[25]=1 at XLEN=32 -> err=1. imm_type=111 -> imm=0, err=1, and stat_err_cnt=2 when the stats macro is defined.
- out_ready=0, three requests offered -> two accepted, then in_ready=0. Outputs hold the first request stable. Releasing out_ready drains in order; in_ready returns 1 the cycle after the first pop.
- XLEN=64: I-type -1 -> 0xFFFFFFFFFFFFFFFF; U-type 0x800000B7 -> 0xFFFFFFFF80000000; SHAMT raw_src[25:20]=0x3F -> 0x3F with err=0.
- Assert rst_n low while 2 entries are buffered -> out_valid=0 immediately, in_ready=1 after release, and no stale result appears.
